miriscv_lsu: RTL

// - Core-side load/store unit: the initiator of the data memory interface served by the SoC RAM.
// - Converts one core load/store (byte/half/word, signed/unsigned) into one req/rvalid transaction.
// - Generates byte enables and lane-replicated write data, and extracts and extends load data.
// - Stalls the pipeline until rvalid, or until a timeout fires.

---
 rtl/miriscv_lsu_pkg.sv | 14 +
 rtl/miriscv_lsu_align.sv | 60 ++++++
 rtl/miriscv_lsu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/miriscv_lsu_pkg.sv
// miriscv load/store unit: shared types.
// Access size encodings and LSU FSM states.
package miriscv_lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/miriscv_lsu_align.sv
// miriscv load/store unit: lane alignment.
// Byte enables, store replication, misalign check, load extension.
module miriscv_lsu_align
  import miriscv_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic        misalign_o,
  output logic [31:0] rdata_ext_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // pick the addressed byte/half out of the response word
  always_comb begin
    lane_b = rdata_i[7:0];
    unique case (offset_i)
      2'd0: lane_b = rdata_i[7:0];
      2'd1: lane_b = rdata_i[15:8];
      2'd2: lane_b = rdata_i[23:16];
      2'd3: lane_b = rdata_i[31:24];
      default: lane_b = rdata_i[7:0];
    endcase
    lane_h = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // per-size enables, replication, alignment and extension
  always_comb begin
    be_o        = 4'b1111;
    wdata_rep_o = wdata_i;
    misalign_o  = 1'b0;
    rdata_ext_o = rdata_i;
    unique case (size_i)
      LSU_BYTE: begin
        be_o        = 4'b0001 << offset_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_ext_o = {{24{~uns_i & lane_b[7]}}, lane_b};
      end
      LSU_HALF: begin
        be_o        = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        misalign_o  = offset_i[0];
        rdata_ext_o = {{16{~uns_i & lane_h[15]}}, lane_h};
      end
      default: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        misalign_o  = |offset_i;
        rdata_ext_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// miriscv load/store unit: top level.
// One req/rvalid transaction per core access, with rvalid timeout.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int RVALID_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_uns_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_stall_o,
  output logic        lsu_misalign_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  localparam int CW = $clog2(RVALID_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(RVALID_TIMEOUT - 1);

  lsu_state_t    state_q, state_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        in_wait;
  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic [31:0] al_rdata;
  logic        issue;
  logic        resp;
  logic        tmo;

  // live request context while idle, stored context while waiting
  assign in_wait = (state_q == WAIT);
  assign al_size = in_wait ? size_q : lsu_size_i;
  assign al_off  = in_wait ? off_q : lsu_addr_i[1:0];
  assign al_uns  = in_wait ? uns_q : lsu_uns_i;

  miriscv_lsu_align u_align (
    .size_i      (al_size),
    .offset_i    (al_off),
    .uns_i       (al_uns),
    .wdata_i     (lsu_wdata_i),
    .rdata_i     (data_rdata_i),
    .be_o        (al_be),
    .wdata_rep_o (al_wdata),
    .misalign_o  (al_mis),
    .rdata_ext_o (al_rdata)
  );

  assign issue = ~in_wait & lsu_req_i & ~al_mis;
  assign resp  = in_wait & data_rvalid_i;
  assign tmo   = in_wait & ~data_rvalid_i & (cnt_q == CNT_LAST);

  // state, request context and timeout counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: issue from IDLE, leave WAIT on response or timeout
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = WAIT;
          off_d   = lsu_addr_i[1:0];
          size_d  = lsu_size_i;
          uns_d   = lsu_uns_i;
          we_d    = lsu_we_i;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (resp || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs, forced to zero while reset is asserted
  always_comb begin
    lsu_rdata_o    = '0;
    lsu_stall_o    = 1'b0;
    lsu_misalign_o = 1'b0;
    lsu_err_o      = 1'b0;
    data_req_o     = 1'b0;
    data_we_o      = 1'b0;
    data_be_o      = '0;
    data_addr_o    = '0;
    data_wdata_o   = '0;
    if (arstn_i) begin
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i && al_mis) begin
            lsu_misalign_o = 1'b1;
          end else if (lsu_req_i) begin
            data_req_o   = 1'b1;
            data_we_o    = lsu_we_i;
            data_be_o    = al_be;
            data_addr_o  = {lsu_addr_i[31:2], 2'b00};
            data_wdata_o = al_wdata;
            lsu_stall_o  = 1'b1;
          end
        end
        WAIT: begin
          lsu_stall_o = ~(resp | tmo);
          lsu_err_o   = tmo;
          if (resp && !we_q) lsu_rdata_o = al_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
